// File: rtl/seq_mult_pkg.sv
// Shared definitions for the digit-serial multiplier: FSM encoding, sizing
// helpers and parameter legality.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // The digit counter is never narrower than one bit, even when N == 1.
    function automatic int cnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic bit params_legal(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/seq_mult_param_mult_digit.sv
// Combinational WIDTH x DIGIT unsigned partial-product generator; one
// shifted copy of the multiplicand per set bit of the digit, summed.
module mult_digit
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic [WIDTH-1:0]       a,
    input  logic [DIGIT-1:0]       d,
    output logic [WIDTH+DIGIT-1:0] p
);

    localparam int PW = WIDTH + DIGIT;

    logic [PW-1:0] row [DIGIT];

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_row
            assign row[gi] = d[gi] ? (PW'(a) << gi) : '0;
        end
    endgenerate

    // a * d < 2^(WIDTH+DIGIT), so the row sum cannot overflow PW bits.
    always_comb begin
        p = '0;
        for (int i = 0; i < DIGIT; i++) begin
            p = p + row[i];
        end
    end

endmodule

// File: rtl/seq_mult_param.sv
// Digit-serial WIDTH x WIDTH multiplier with valid/ready handshakes on both
// sides; retires DIGIT multiplier bits per BUSY cycle, signed or unsigned.
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam int PW = WIDTH + DIGIT;
    localparam int OW = 2 * WIDTH;

    generate
        if (!params_legal(WIDTH, DIGIT)) begin : g_param_err
            $error("seq_mult_param: WIDTH must be a multiple of DIGIT and 1 <= DIGIT <= WIDTH");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0] ma_q, ma_d;
    logic [WIDTH-1:0] mb_q, mb_d;
    logic            neg_q, neg_d;
    logic [OW-1:0]   out_q, out_d;
    logic            out_valid_q, out_valid_d;

    logic [PW-1:0]   pp;
    logic [OW-1:0]   pp_ext;
    logic [31:0]     shamt;
    logic [OW-1:0]   sum;

    // The multiplier register shifts right each BUSY cycle, so the digit
    // being retired always sits in its low DIGIT bits.
    mult_digit #(
        .WIDTH(WIDTH),
        .DIGIT(DIGIT)
    ) u_digit (
        .a(ma_q),
        .d(mb_q[DIGIT-1:0]),
        .p(pp)
    );

    always_comb begin
        pp_ext = OW'(pp);
        shamt  = 32'(cnt_q) * 32'(DIGIT);
        sum    = acc_q + (pp_ext << shamt);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        neg_d       = neg_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // |0x80..0| stays 0x80..0, which is correct as an unsigned magnitude.
                    ma_d    = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
                    mb_d    = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
                    neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = sum;
                mb_d  = mb_q >> DIGIT;
                if (cnt_q == CW'(N - 1)) begin
                    out_d       = neg_q ? (OW'(0) - sum) : sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            neg_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            neg_q       <= neg_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param at WIDTH=32, DIGIT=8: handshake timing,
// signed/unsigned products, back-pressure, back-to-back and mid-op reset.
module tb_seq_mult_param;

    localparam int WIDTH = 32;
    localparam int DIGIT = 8;
    localparam int N     = WIDTH / DIGIT;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              is_signed;
    logic              out_valid;
    logic              out_ready;
    logic [2*WIDTH-1:0] out;
    logic              busy;

    int total;
    int bad;

    seq_mult_param #(
        .WIDTH(WIDTH),
        .DIGIT(DIGIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .is_signed(is_signed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out(out),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation, wait for its accept, then wait for out_valid.
    // lat = number of edges after the accept edge until out_valid is seen.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                          output logic [63:0] prod, output int lat, output bit ok);
        int n;
        a = ta; b = tb_v; is_signed = ts; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready=%0b required=1", in_ready);
            in_valid = 1'b0; prod = '0; lat = -1; ok = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Disturb operands after acceptance; they must have no effect.
        a = $urandom; b = $urandom; is_signed = ~ts;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        prod = out;
        ok = out_valid;
        if (!ok) begin
            total++; bad++;
            $display("FAIL result_timeout: out_valid=%0b required=1", out_valid);
        end
    endtask

    task automatic check_op(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                            input logic ts, input logic [63:0] exp_p);
        logic [63:0] p;
        int lat;
        bit ok;
        run_op(ta, tb_v, ts, p, lat, ok);
        if (ok) begin
            total++;
            if (p !== exp_p) begin
                bad++;
                $display("FAIL %s: out=%h required=%h", name, p, exp_p);
            end
            total++;
            if (lat !== N) begin
                bad++;
                $display("FAIL %s_latency: cycles=%0d required=%0d", name, lat, N);
            end
            $display("op %s a=%h b=%h s=%0b out=%h lat=%0d", name, ta, tb_v, ts, p, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; is_signed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out !== 64'h0) begin
            bad++;
            $display("FAIL reset_state: ov=%0b ir=%0b busy=%0b out=%h required ov=0 ir=1 busy=0 out=0",
                     out_valid, in_ready, busy, out);
        end
        $display("reset ov=%0b ir=%0b busy=%0b out=%h", out_valid, in_ready, busy, out);
    endtask

    task automatic test_unsigned();
        out_ready = 1'b1;
        check_op("u_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001);
        check_op("u_shift", 32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000);
    endtask

    task automatic test_signed();
        out_ready = 1'b1;
        check_op("s_neg3x7", 32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFFFFFFFFEB);
        check_op("s_minsq", 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000);
        check_op("s_m1m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001);
        check_op("s_maxmin", 32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000);
    endtask

    task automatic test_backpressure();
        logic [63:0] p;
        logic [63:0] held;
        int lat;
        bit ok;
        int errs;
        out_ready = 1'b0;
        run_op(32'd3, 32'd4, 1'b0, p, lat, ok);
        if (ok) begin
            total++;
            if (p !== 64'd12) begin
                bad++;
                $display("FAIL bp_result: out=%h required=%h", p, 64'd12);
            end
            held = p;
            a = 32'd9; b = 32'd9; is_signed = 1'b0; in_valid = 1'b1;
            errs = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (out !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) errs++;
            end
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL bp_hold: bad_cycles=%0d required=0 (out=%h ov=%0b ir=%0b)",
                         errs, out, out_valid, in_ready);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 64'd12) begin
                bad++;
                $display("FAIL bp_release: ov=%0b ir=%0b out=%h required ov=0 ir=1 out=%h",
                         out_valid, in_ready, out, 64'd12);
            end
            @(posedge clk); #1;
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL bp_no_accept: busy=%0b required=0", busy);
            end
            $display("op backpressure out=%h held_cycles=10", held);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [63:0] ve [3];
        int acc_cyc [3];
        int cyc;
        int n;
        va[0] = 32'd12345; vb[0] = 32'd678;        ve[0] = 64'd8369910;
        va[1] = 32'd0;     vb[1] = 32'hDEADBEEF;   ve[1] = 64'd0;
        va[2] = 32'd1;     vb[2] = 32'hFFFFFFFF;   ve[2] = 64'h00000000FFFFFFFF;
        out_ready = 1'b1;
        cyc = 0;
        is_signed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = va[i]; b = vb[i]; in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 20) begin
                @(posedge clk); #1; cyc++; n++;
            end
            @(posedge clk); #1; cyc++;
            acc_cyc[i] = cyc;
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk); #1; cyc++; n++;
            end
            total++;
            if (out_valid !== 1'b1 || out !== ve[i]) begin
                bad++;
                $display("FAIL b2b_result%0d: ov=%0b out=%h required ov=1 out=%h", i, out_valid, out, ve[i]);
            end
            $display("op b2b%0d a=%h b=%h out=%h accept_cycle=%0d", i, va[i], vb[i], out, acc_cyc[i]);
        end
        for (int i = 1; i < 3; i++) begin
            total++;
            if (acc_cyc[i] - acc_cyc[i-1] != N + 2) begin
                bad++;
                $display("FAIL b2b_spacing%0d: interval=%0d required=%0d", i, acc_cyc[i] - acc_cyc[i-1], N + 2);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        out_ready = 1'b1;
        a = 32'h00001234; b = 32'h00005678; is_signed = 1'b0; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 64'h0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_state: ov=%0b ir=%0b busy=%0b out=%h required ov=0 ir=1 busy=0 out=0",
                     out_valid, in_ready, busy, out);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midrst_no_product: valid_cycles=%0d required=0", seen);
        end
        $display("op midreset ov=%0b ir=%0b out=%h", out_valid, in_ready, out);
        check_op("after_rst", 32'd5, 32'd5, 1'b0, 64'd25);
    endtask

    task automatic test_random();
        logic [63:0] p;
        logic [63:0] exp_p;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [31:0] ra;
        logic [31:0] rb;
        logic rs;
        int lat;
        bit ok;
        int errs;
        out_ready = 1'b1;
        errs = 0;
        for (int i = 0; i < 200; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            if (rs) begin
                sa = $signed({{32{ra[31]}}, ra});
                sb = $signed({{32{rb[31]}}, rb});
                exp_p = 64'(sa * sb);
            end else begin
                exp_p = {32'h0, ra} * {32'h0, rb};
            end
            run_op(ra, rb, rs, p, lat, ok);
            if (!ok || p !== exp_p || lat != N) begin
                errs++;
                $display("FAIL rand%0d: a=%h b=%h s=%0b out=%h lat=%0d required out=%h lat=%0d",
                         i, ra, rb, rs, p, lat, exp_p, N);
            end
            @(posedge clk); #1;
        end
        total++;
        if (errs != 0) bad++;
        $display("op random count=200 errors=%0d", errs);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; is_signed = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
